memory_sdp: RTL and testbench
=============================

// Module: memory_sdp
// PURPOSE
// - Simple-dual-port synchronous RAM with byte-enable writes and a valid-tagged read pipeline.
// - Read latency is configurable; read-during-write behaviour is selectable.
// - A post-reset init sweep writes a known value to every word.
// - Shared frame/sample store for the audio/video datapaths; replaces the single-port 24-bit store.
// PARAMETERS
// word_size   24   data width in bits; must be a multiple of 8
// n_words     512  depth in words; need not be a power of 2
// RD_LAT      1    read latency in cycles; legal values 1 or 2 (2 adds an output register)
// RDW_MODE    0    same-address read+write in one cycle: 0 = OLD data, 1 = NEW data (bypass)
// INIT_VALUE  0    word value written to every location by the init sweep
// PORTS
// clk       in   1                  rising-edge clock
// reset     in   1                  synchronous, active-high
// init_busy out  1                  1 while reset is high or the init sweep is running
// we        in   1                  write strobe
// wa        in   $clog2(n_words)    write address
// din       in   word_size          write data
// be        in   word_size/8        byte enables; bit i covers din[8i+7:8i]
// re        in   1                  read request
// ra        in   $clog2(n_words)    read address
// rd_valid  out  1                  rd_data is valid this cycle
// dout      out  word_size          read data; holds its last value when rd_valid=0
// BEHAVIOUR
// - Reset: rd_valid=0, dout=0, init_busy=1. The read pipeline is flushed.
//   - Any re issued in the cycles before reset never produces rd_valid.
// - Init sweep
//   - Starts on the first cycle with reset=0.
//   - Writes INIT_VALUE to address 0..n_words-1, one word per cycle, all bytes.
//   - init_busy drops to 0 in the cycle after address n_words-1 is written (n_words cycles total).
//   - Reset asserted mid-sweep restarts the sweep from address 0.
// - While init_busy=1: we and re are ignored. No user write happens, and rd_valid stays 0.
// - Write: when we=1, init_busy=0 and wa<n_words, each byte i with be[i]=1 is updated at the clock edge.
//   - Bytes with be[i]=0 are left unchanged.
// - Read
//   - re=1 at edge N with init_busy=0 -> rd_valid=1 and dout=mem[ra] after edge N+RD_LAT-1.
//   - rd_valid is high for exactly one cycle per accepted request.
//   - Back-to-back requests give one result per cycle, returned in request order.
// - Out of range: wa>=n_words drops the write silently. ra>=n_words returns dout=0, with rd_valid still asserted.
// - Read-during-write, same address, same edge
//   - RDW_MODE=0: returns the pre-write word.
//   - RDW_MODE=1: returns the merged word, i.e. new bytes where be=1 and old bytes elsewhere.
// - Different addresses on the same edge do not interact.
// - Writes in earlier cycles are always visible to later reads, whatever RD_LAT.
// - No backpressure: the consumer must take dout whenever rd_valid=1.
// STRUCTURE
// - memory_pkg
//   - rdw_mode_t enum: RDW_OLD, RDW_NEW
//   - function lanes(word_size) = word_size/8
//   - byte-merge function merge(old, new, be)
// - Sub-module memory_init_seq: sweep counter, busy flag, and write-address/data mux override.
// - The top level holds the storage array, the byte-lane write loop, the RDW bypass, and the RD_LAT valid/data shift stage.
// - Elaboration-time assertions: word_size%8==0; RD_LAT in {1,2}; RDW_MODE in {0,1}.
// TESTING
// - Init: release reset, count cycles -> init_busy high for exactly 512 cycles.
//   - Afterwards, reading addr 0, 255 and 511 returns 24'h000000.
// - Byte enables: write 0xAABBCC with be=111 to addr 7, then 0x112233 with be=010.
//   - Reading addr 7 returns 0xAA22CC.
// - RDW: mem[5]=0x000001; on one edge write 0x000002 (be=111) to addr 5 and read addr 5.
//   - RDW_MODE=0 returns 0x000001; RDW_MODE=1 returns 0x000002.
// - Latency/streaming: RD_LAT=2, re=1 for addresses 0..9 on consecutive cycles.
//   - rd_valid goes high 2 edges after the first request and stays high for 10 cycles, data in order.
// - Reset mid-operation
//   - Assert reset at sweep address 100 -> sweep restarts at 0, init_busy stays high for another full 512 cycles.
//   - Reset with a read in flight -> no rd_valid pulse.
// - Out of range: n_words=500, write 0xFFFFFF to addr 505, then read addr 505.
//   - Returns 0 with rd_valid=1; addr 499 is unaffected.

Source files
------------

// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared types and helpers for the memory_sdp simple-dual-port RAM.
//   rdw_mode_t : read-during-write selection (old word or merged new word)
//   lanes()    : number of byte lanes in a word
//   merge()    : byte-enable merge of a new word over an old word
// merge() works on a fixed maximum width; callers widen their operands and
// truncate the result back to their own word size.
// -----------------------------------------------------------------------------
package memory_pkg;

    typedef enum logic [0:0] {
        RDW_OLD = 1'b0,
        RDW_NEW = 1'b1
    } rdw_mode_t;

    localparam int MAX_WORD  = 256;
    localparam int MAX_LANES = MAX_WORD / 8;

    typedef logic [MAX_WORD-1:0]  word_max_t;
    typedef logic [MAX_LANES-1:0] be_max_t;

    function automatic int lanes(input int word_size);
        return word_size / 8;
    endfunction

    function automatic word_max_t merge(input word_max_t old_word,
                                        input word_max_t new_word,
                                        input be_max_t   be);
        word_max_t res;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/memory_sdp_if.sv
// -----------------------------------------------------------------------------
// memory_sdp_if
// Bus bundle for memory_sdp.
//   write side : we, wa, din, be
//   read side  : re, ra -> rd_valid, dout
//   status     : init_busy
// master = user of the RAM, slave = the RAM.
// -----------------------------------------------------------------------------
interface memory_sdp_if #(
    parameter int word_size = 24,
    parameter int n_words   = 512
);
    localparam int AW    = (n_words > 1) ? $clog2(n_words) : 1;
    localparam int LANES = memory_pkg::lanes(word_size);

    logic                 init_busy;
    logic                 we;
    logic [AW-1:0]        wa;
    logic [word_size-1:0] din;
    logic [LANES-1:0]     be;
    logic                 re;
    logic [AW-1:0]        ra;
    logic                 rd_valid;
    logic [word_size-1:0] dout;

    modport master (
        input  init_busy, rd_valid, dout,
        output we, wa, din, be, re, ra
    );

    modport slave (
        output init_busy, rd_valid, dout,
        input  we, wa, din, be, re, ra
    );
endinterface

// File: rtl/memory_init_seq.sv
// -----------------------------------------------------------------------------
// memory_init_seq
// Post-reset init sweep for memory_sdp. Writes INIT_VALUE to every word, one
// per cycle, and owns the RAM write port while doing so.
//   clk, reset           : clock, synchronous active-high reset
//   usr_en/addr/data/be  : user write (already range-qualified by the top)
//   busy                 : sweep in progress (registered)
//   wr_en/addr/data/be   : write port actually applied to the storage
// -----------------------------------------------------------------------------
module memory_init_seq #(
    parameter int                   word_size  = 24,
    parameter int                   n_words    = 512,
    parameter logic [word_size-1:0] INIT_VALUE = {word_size{1'b0}},
    localparam int                  AW         = (n_words > 1) ? $clog2(n_words) : 1,
    localparam int                  LANES      = memory_pkg::lanes(word_size)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 usr_en,
    input  logic [AW-1:0]        usr_addr,
    input  logic [word_size-1:0] usr_data,
    input  logic [LANES-1:0]     usr_be,
    output logic                 busy,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [word_size-1:0] wr_data,
    output logic [LANES-1:0]     wr_be
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(n_words - 1);

    logic [AW-1:0] cnt_r;
    logic          busy_r;

    // Sweep counter and busy flag; reset restarts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= {AW{1'b0}};
            busy_r <= 1'b1;
        end else if (busy_r) begin
            if (cnt_r == LAST_ADDR) begin
                cnt_r  <= {AW{1'b0}};
                busy_r <= 1'b0;
            end else begin
                cnt_r  <= cnt_r + AW'(1);
            end
        end else begin
            cnt_r  <= cnt_r;
            busy_r <= busy_r;
        end
    end

    // Write-port mux: the sweep overrides (and blocks) user writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = {AW{1'b0}};
        wr_data = {word_size{1'b0}};
        wr_be   = {LANES{1'b0}};
        if (busy_r) begin
            wr_en   = ~reset;
            wr_addr = cnt_r;
            wr_data = INIT_VALUE;
            wr_be   = {LANES{1'b1}};
        end else begin
            wr_en   = usr_en;
            wr_addr = usr_addr;
            wr_data = usr_data;
            wr_be   = usr_be;
        end
    end

    assign busy = busy_r;
endmodule

// File: rtl/memory_sdp_chk.sv
// -----------------------------------------------------------------------------
// memory_sdp_chk
// Elaboration-time parameter legality checks for memory_sdp. No ports.
// -----------------------------------------------------------------------------
module memory_sdp_chk #(
    parameter int word_size = 24,
    parameter int RD_LAT    = 1,
    parameter int RDW_MODE  = 0
) ();
    if ((word_size % 8) != 0) begin : g_ws_bad
        $error("memory_sdp: word_size must be a multiple of 8");
    end
    if (word_size > memory_pkg::MAX_WORD) begin : g_ws_big
        $error("memory_sdp: word_size exceeds merge() width");
    end
    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_lat_bad
        $error("memory_sdp: RD_LAT must be 1 or 2");
    end
    if ((RDW_MODE != 0) && (RDW_MODE != 1)) begin : g_rdw_bad
        $error("memory_sdp: RDW_MODE must be 0 or 1");
    end
endmodule

// File: rtl/memory_sdp.sv
// -----------------------------------------------------------------------------
// memory_sdp
// Simple-dual-port synchronous RAM with byte-enable writes, a valid-tagged
// read pipeline of RD_LAT (1 or 2) cycles, selectable read-during-write
// behaviour and a post-reset init sweep.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : memory_sdp_if slave (we/wa/din/be, re/ra, rd_valid/dout, init_busy)
// Out-of-range writes are dropped; out-of-range reads return zero but are
// still tagged valid.
// -----------------------------------------------------------------------------
module memory_sdp
    import memory_pkg::*;
#(
    parameter int                   word_size  = 24,
    parameter int                   n_words    = 512,
    parameter int                   RD_LAT     = 1,
    parameter int                   RDW_MODE   = 0,
    parameter logic [word_size-1:0] INIT_VALUE = {word_size{1'b0}}
) (
    input  logic        clk,
    input  logic        reset,
    memory_sdp_if.slave bus
);
    localparam int        AW      = (n_words > 1) ? $clog2(n_words) : 1;
    localparam int        LANES   = lanes(word_size);
    localparam logic [AW:0] N_W   = (AW + 1)'(n_words);
    localparam rdw_mode_t RDW_SEL = (RDW_MODE == 1) ? RDW_NEW : RDW_OLD;

    logic [word_size-1:0] mem_r [n_words];

    logic                 usr_wr_s;
    logic                 busy_s;
    logic                 wr_en_s;
    logic [AW-1:0]        wr_addr_s;
    logic [word_size-1:0] wr_data_s;
    logic [LANES-1:0]     wr_be_s;
    logic                 rd_acc_s;
    logic [word_size-1:0] rd_word_s;
    logic                 v1_r;
    logic [word_size-1:0] d1_r;

    memory_sdp_chk #(
        .word_size (word_size),
        .RD_LAT    (RD_LAT),
        .RDW_MODE  (RDW_MODE)
    ) u_chk ();

    assign usr_wr_s = bus.we & ({1'b0, bus.wa} < N_W);
    assign rd_acc_s = bus.re & ~busy_s;

    memory_init_seq #(
        .word_size  (word_size),
        .n_words    (n_words),
        .INIT_VALUE (INIT_VALUE)
    ) u_init (
        .clk      (clk),
        .reset    (reset),
        .usr_en   (usr_wr_s),
        .usr_addr (bus.wa),
        .usr_data (bus.din),
        .usr_be   (bus.be),
        .busy     (busy_s),
        .wr_en    (wr_en_s),
        .wr_addr  (wr_addr_s),
        .wr_data  (wr_data_s),
        .wr_be    (wr_be_s)
    );

    // Storage write, one byte lane at a time.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be_s[i]) begin
                    mem_r[wr_addr_s][8*i +: 8] <= wr_data_s[8*i +: 8];
                end
            end
        end
    end

    // Read word select: range check, then optional same-address bypass.
    always_comb begin
        rd_word_s = {word_size{1'b0}};
        if ({1'b0, bus.ra} >= N_W) begin
            rd_word_s = {word_size{1'b0}};
        end else if ((RDW_SEL == RDW_NEW) && usr_wr_s && !busy_s && (bus.wa == bus.ra)) begin
            rd_word_s = word_size'(merge(word_max_t'(mem_r[bus.ra]),
                                         word_max_t'(bus.din),
                                         be_max_t'(bus.be)));
        end else begin
            rd_word_s = mem_r[bus.ra];
        end
    end

    // First read stage; data only loads on an accepted request so dout holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r <= 1'b0;
            d1_r <= {word_size{1'b0}};
        end else begin
            v1_r <= rd_acc_s;
            if (rd_acc_s) begin
                d1_r <= rd_word_s;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic                 v2_r;
        logic [word_size-1:0] d2_r;

        // Extra output register stage.
        always_ff @(posedge clk) begin
            if (reset) begin
                v2_r <= 1'b0;
                d2_r <= {word_size{1'b0}};
            end else begin
                v2_r <= v1_r;
                if (v1_r) begin
                    d2_r <= d1_r;
                end
            end
        end

        assign bus.rd_valid = v2_r;
        assign bus.dout     = d2_r;
    end else begin : g_lat1
        assign bus.rd_valid = v1_r;
        assign bus.dout     = d1_r;
    end

    assign bus.init_busy = busy_s;
endmodule

// File: tb/tb_memory_sdp.sv
// -----------------------------------------------------------------------------
// tb_memory_sdp
// Two instances: dut0 (512 words, RD_LAT=1, old-data RDW) and dut1
// (500 words, RD_LAT=2, new-data RDW). Expected read words are queued when a
// read is driven and popped by a negedge monitor when rd_valid is seen.
// -----------------------------------------------------------------------------
module tb_memory_sdp;
    logic clk;
    logic reset0;
    logic reset1;

    int checks = 0;
    int errors = 0;

    logic [23:0] q0[$];
    logic [23:0] q1[$];

    memory_sdp_if #(.word_size(24), .n_words(512)) if0 ();
    memory_sdp_if #(.word_size(24), .n_words(500)) if1 ();

    memory_sdp #(
        .word_size(24), .n_words(512), .RD_LAT(1), .RDW_MODE(0), .INIT_VALUE(24'h000000)
    ) dut0 (.clk(clk), .reset(reset0), .bus(if0));

    memory_sdp #(
        .word_size(24), .n_words(500), .RD_LAT(2), .RDW_MODE(1), .INIT_VALUE(24'h000000)
    ) dut1 (.clk(clk), .reset(reset1), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [8:0] a, input logic [23:0] d, input logic [2:0] b);
        if0.we = 1'b1; if0.wa = a; if0.din = d; if0.be = b;
        tick();
        if0.we = 1'b0;
    endtask

    task automatic wr1(input logic [8:0] a, input logic [23:0] d, input logic [2:0] b);
        if1.we = 1'b1; if1.wa = a; if1.din = d; if1.be = b;
        tick();
        if1.we = 1'b0;
    endtask

    task automatic rd0(input logic [8:0] a, input logic [23:0] e);
        if0.re = 1'b1; if0.ra = a; q0.push_back(e);
        tick();
        if0.re = 1'b0;
    endtask

    task automatic rd1(input logic [8:0] a, input logic [23:0] e);
        if1.re = 1'b1; if1.ra = a; q1.push_back(e);
        tick();
        if1.re = 1'b0;
    endtask

    // Scoreboard: every rd_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (if0.rd_valid === 1'b1) begin
            if (q0.size() == 0) check("rd0_unexpected", 32'(if0.rd_valid), 32'd0);
            else                check("rd0_data", 32'(if0.dout), 32'(q0.pop_front()));
        end
        if (if1.rd_valid === 1'b1) begin
            if (q1.size() == 0) check("rd1_unexpected", 32'(if1.rd_valid), 32'd0);
            else                check("rd1_data", 32'(if1.dout), 32'(q1.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int done0;
        int done1;
        logic [11:0] hist;

        reset0 = 1'b1; reset1 = 1'b1;
        // User traffic held active through reset and the sweep; it must be ignored.
        if0.we = 1'b1; if0.wa = 9'd0; if0.din = 24'hFFFFFF; if0.be = 3'b111;
        if0.re = 1'b1; if0.ra = 9'd0;
        if1.we = 1'b1; if1.wa = 9'd0; if1.din = 24'hFFFFFF; if1.be = 3'b111;
        if1.re = 1'b1; if1.ra = 9'd0;
        repeat (3) tick();

        check("rst_valid0", 32'(if0.rd_valid), 32'd0);
        check("rst_dout0",  32'(if0.dout),     32'd0);
        check("rst_busy0",  32'(if0.init_busy), 32'd1);
        check("rst_valid1", 32'(if1.rd_valid), 32'd0);
        check("rst_dout1",  32'(if1.dout),     32'd0);
        check("rst_busy1",  32'(if1.init_busy), 32'd1);

        // Init sweep length, counted in edges after reset release.
        reset0 = 1'b0; reset1 = 1'b0;
        n = 0; done0 = 0; done1 = 0;
        while (((done0 == 0) || (done1 == 0)) && (n < 2000)) begin
            tick();
            n++;
            if ((done0 == 0) && (if0.init_busy == 1'b0)) begin
                done0 = n; if0.we = 1'b0; if0.re = 1'b0;
            end
            if ((done1 == 0) && (if1.init_busy == 1'b0)) begin
                done1 = n; if1.we = 1'b0; if1.re = 1'b0;
            end
        end
        if0.we = 1'b0; if0.re = 1'b0; if1.we = 1'b0; if1.re = 1'b0;
        check("init_cycles0", 32'(done0), 32'd512);
        check("init_cycles1", 32'(done1), 32'd500);

        // Post-init contents, back-to-back reads.
        rd0(9'd0,   24'h000000);
        rd0(9'd255, 24'h000000);
        rd0(9'd511, 24'h000000);
        repeat (3) tick();

        // Byte enables and dout hold.
        wr0(9'd7, 24'hAABBCC, 3'b111);
        wr0(9'd7, 24'h112233, 3'b010);
        rd0(9'd7, 24'hAA22CC);
        tick();
        check("dout_hold_valid", 32'(if0.rd_valid), 32'd0);
        check("dout_hold_data",  32'(if0.dout),     32'h00AA22CC);

        // Read-during-write, old data (dut0) and merged new data (dut1).
        wr0(9'd5, 24'h000001, 3'b111);
        if0.we = 1'b1; if0.wa = 9'd5; if0.din = 24'h000002; if0.be = 3'b111;
        rd0(9'd5, 24'h000001);
        if0.we = 1'b0;
        rd0(9'd5, 24'h000002);
        wr1(9'd5, 24'h000001, 3'b111);
        if1.we = 1'b1; if1.wa = 9'd5; if1.din = 24'h000002; if1.be = 3'b111;
        rd1(9'd5, 24'h000002);
        if1.we = 1'b0;
        if1.we = 1'b1; if1.wa = 9'd6; if1.din = 24'h00AB00; if1.be = 3'b010;
        rd1(9'd6, 24'h00AB00);
        if1.we = 1'b0;
        repeat (4) tick();

        // Streaming with RD_LAT=2.
        for (int i = 0; i < 10; i++) wr1(9'(i), 24'h000100 + 24'(i), 3'b111);
        for (int i = 0; i < 10; i++) begin
            if1.re = 1'b1; if1.ra = 9'(i); q1.push_back(24'h000100 + 24'(i));
            tick();
            hist[i] = if1.rd_valid;
        end
        if1.re = 1'b0;
        for (int i = 10; i < 12; i++) begin
            tick();
            hist[i] = if1.rd_valid;
        end
        check("stream_valid_pattern", 32'(hist), 32'h000007FE);
        repeat (3) tick();

        // Out-of-range write dropped, read returns zero with valid.
        wr1(9'd499, 24'h5A5A5A, 3'b111);
        wr1(9'd505, 24'hFFFFFF, 3'b111);
        rd1(9'd505, 24'h000000);
        rd1(9'd499, 24'h5A5A5A);
        repeat (4) tick();

        // Reset with a read in flight on the two-stage pipeline.
        if1.re = 1'b1; if1.ra = 9'd3;
        tick();
        if1.re = 1'b0; reset1 = 1'b1;
        tick();
        check("flush_valid_a", 32'(if1.rd_valid), 32'd0);
        tick();
        check("flush_valid_b", 32'(if1.rd_valid), 32'd0);
        check("flush_busy",    32'(if1.init_busy), 32'd1);
        reset1 = 1'b0;
        repeat (3) tick();

        // Reset mid-sweep restarts the full sweep.
        reset0 = 1'b1;
        tick();
        reset0 = 1'b0;
        repeat (100) tick();
        check("midsweep_busy", 32'(if0.init_busy), 32'd1);
        reset0 = 1'b1;
        tick();
        reset0 = 1'b0;
        n = 0; done0 = 0;
        while ((done0 == 0) && (n < 2000)) begin
            tick();
            n++;
            if (if0.init_busy == 1'b0) done0 = n;
        end
        check("restart_cycles0", 32'(done0), 32'd512);
        rd0(9'd7, 24'h000000);
        repeat (4) tick();

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
